// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer with opcode dispatch table, conditional branches and a trapping return stack.
module micro_sequencer #(
  parameter int ADDR_W = 8,
  parameter int OP_W = 8,
  parameter int NUM_OPS = 16,
  parameter int FLAG_W = 4,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic [2:0] seq_op,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [$clog2(FLAG_W)-1:0] cond_sel,
  input  logic cond_inv,
  input  logic [FLAG_W-1:0] flags,
  input  logic [OP_W-1:0] opcode,
  input  logic map_we,
  input  logic [$clog2(NUM_OPS)-1:0] map_idx,
  input  logic [ADDR_W-1:0] map_addr,
  input  logic err_clr,
  output logic [ADDR_W-1:0] micro_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic err,
  output logic [1:0] err_cause
);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int PW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam int IW = $clog2(NUM_OPS);
  localparam logic [2:0] OP_NEXT = 3'd0, OP_DISPATCH = 3'd1, OP_FETCH = 3'd2, OP_JUMP = 3'd3,
                         OP_BRANCH = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6, OP_HOLD = 3'd7;
  logic [ADDR_W-1:0] map_tbl [NUM_OPS];
  logic [NUM_OPS-1:0] map_vld;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] inc, nxt;
  logic [SW-1:0] lvl_dec;
  logic hit, cond, full, empty, push, pop, op_err, new_err;
  logic [1:0] new_cause;
  always_comb begin
    inc = micro_addr + ADDR_W'(1);
    lvl_dec = stack_level - SW'(1);
    hit = (32'(opcode) < NUM_OPS) && map_vld[opcode[IW-1:0]];
    cond = ((32'(cond_sel) < FLAG_W) ? flags[cond_sel] : 1'b0) ^ cond_inv;
    full = stack_level == SW'(STACK_DEPTH);
    empty = stack_level == '0;
    nxt = micro_addr;
    push = 1'b0;
    pop = 1'b0;
    op_err = 1'b0;
    new_cause = 2'b00;
    case (seq_op)
      OP_NEXT:     nxt = inc;
      OP_DISPATCH: begin
        nxt = hit ? map_tbl[opcode[IW-1:0]] : TRAP_ADDR;
        op_err = !hit;
        new_cause = 2'b01;
      end
      OP_FETCH:    nxt = RESET_ADDR;
      OP_JUMP:     nxt = br_target;
      OP_BRANCH:   nxt = cond ? br_target : inc;
      OP_CALL:     begin
        nxt = full ? TRAP_ADDR : br_target;
        push = !full;
        op_err = full;
        new_cause = 2'b10;
      end
      OP_RET:      begin
        nxt = empty ? TRAP_ADDR : stack[lvl_dec[PW-1:0]];
        pop = !empty;
        op_err = empty;
        new_cause = 2'b11;
      end
      default:     nxt = micro_addr;
    endcase
    new_err = op_err && !stall;
  end
  // Table and stack payloads need no reset: valid bits and stack_level gate every read.
  always_ff @(posedge clk) begin
    if (map_we) map_tbl[map_idx] <= map_addr;
    if (push && !stall) stack[stack_level[PW-1:0]] <= inc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      micro_addr <= RESET_ADDR;
      stack_level <= '0;
      map_vld <= '0;
      err <= 1'b0;
      err_cause <= 2'b00;
    end else begin
      if (map_we) map_vld[map_idx] <= 1'b1;
      if (!stall) begin
        micro_addr <= nxt;
        stack_level <= push ? stack_level + SW'(1) : pop ? lvl_dec : stack_level;
      end
      if (new_err && (!err || err_clr)) begin
        err <= 1'b1;
        err_cause <= new_cause;
      end else if (err_clr) begin
        err <= 1'b0;
        err_cause <= 2'b00;
      end
    end
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised microprogram sequencer; next generation of the control address register.
- Holds the current control-memory address and computes the next one each clock from a decoded sequencing field of the current microword.
- Adds a writable opcode dispatch table, flag-selectable conditional branches, and a micro-subroutine return stack with error trapping.
- Sits between the control unit's instruction register and control memory; drives the control memory read address.

Parameters:
- ADDR_W, 8: micro-address width.
- OP_W, 8: opcode width.
- NUM_OPS, 16: dispatch table entries; opcodes >= NUM_OPS are unmapped.
- FLAG_W, 4: number of condition flags (>= 2).
- STACK_DEPTH, 4: return-stack entries (>= 1).
- RESET_ADDR, 0: reset, fetch and start address.
- TRAP_ADDR, 8'hFF: error-handler micro-address.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  freeze the sequencer this cycle.
- seq_op  input  3  sequencing operation from the microword.
- br_target  input  ADDR_W  jump/branch/call target from the microword.
- cond_sel  input  $clog2(FLAG_W)  flag index for BRANCH.
- cond_inv  input  1  invert the selected flag.
- flags  input  FLAG_W  ALU/status flags; bit 0 = accumulator >= 0.
- opcode  input  OP_W  instruction-register opcode.
- map_we  input  1  dispatch table write enable.
- map_idx  input  $clog2(NUM_OPS)  table entry to write.
- map_addr  input  ADDR_W  entry address to write.
- err_clr  input  1  clear the sticky error.
- micro_addr  output  ADDR_W  current control-memory address.
- stack_level  output  $clog2(STACK_DEPTH+1)  number of occupied stack entries.
- err  output  1  sticky error flag.
- err_cause  output  2  error cause: 01 unmapped opcode, 10 stack overflow, 11 stack underflow.

Behaviour:
- Reset (async assert, sync release effect):
  - micro_addr = RESET_ADDR; stack_level = 0.
  - All table valid bits cleared.
  - err = 0; err_cause = 00.
- All state updates on the rising edge of clk. Next micro_addr appears one cycle after seq_op is presented; no combinational path from inputs to micro_addr.
- seq_op encoding:
  - 0 NEXT: micro_addr + 1, modulo 2^ADDR_W (all-ones wraps to 0).
  - 1 DISPATCH: table[opcode] if opcode < NUM_OPS and the entry is valid; otherwise TRAP_ADDR, with err = 1 and err_cause = 01.
  - 2 FETCH: RESET_ADDR.
  - 3 JUMP: br_target.
  - 4 BRANCH: c = flags[cond_sel] XOR cond_inv. If c = 1, br_target; else micro_addr + 1. cond_sel >= FLAG_W gives c = cond_inv.
  - 5 CALL: push micro_addr + 1 (wrapped), go to br_target. If the stack is full: no push, go to TRAP_ADDR, err_cause = 10.
  - 6 RET: pop, go to the popped address. If the stack is empty: go to TRAP_ADDR, err_cause = 11.
  - 7 HOLD: micro_addr unchanged.
- stall = 1: micro_addr, stack, stack_level and err are unchanged; seq_op is ignored. Table writes and err_clr still take effect.
- Table write: map_we writes table[map_idx] = map_addr and sets its valid bit. A write and a DISPATCH of the same index in the same cycle: DISPATCH uses the old contents/valid bit; the new value is visible next cycle.
- err is sticky; err_cause holds the first cause until cleared.
  - A new error while err = 1 does not change err_cause.
  - err_clr clears both, except when a new error occurs in the same cycle: the new error wins and err_cause takes the new cause.
- Stack is LIFO. stack_level updates in the same edge as the push/pop. Stack contents are not cleared on pop.
- Reset asserted mid-operation aborts immediately: returns to reset state, table is invalidated, and software must reload it.

Test Plan:
- Reset, then 3× NEXT → micro_addr 0,1,2,3. Set micro_addr to 8'hFE via JUMP, then 2× NEXT → FE, FF, 00.
- Write table[1]=04, table[5]=1B. opcode=05, DISPATCH → 1B. opcode=03 (unwritten), DISPATCH → FF, err=1, err_cause=01. err_clr → err=0.
- flags=4'b0001: BRANCH cond_sel=0, cond_inv=0, target 1B at addr 10 → 1B. Same with cond_inv=1 → 11.
- At addr 20: CALL 40, at addr 40: CALL 50, then RET, RET → 40, 50, 41, 21; stack_level 1, 2, 1, 0. A 5th nested CALL with depth 4 → FF, err_cause=10. RET on empty → FF, err_cause=11.
- stall=1 with seq_op=JUMP 30 for 3 cycles → micro_addr frozen. Same-cycle map_we writes table[2]=33 → DISPATCH opcode 2 after stall release gives 33.
- Assert rst_n=0 asynchronously mid-CALL chain → micro_addr=00, stack_level=0 without a clock edge. Previously valid opcode then traps on DISPATCH.
